// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width default and Gray/binary conversion helpers shared by both FIFO pointer blocks.
// The helpers work on zero-extended 32-bit values, so they serve any pointer width up to 32.
package fifo_pkg;
   localparam int WIDTH_DEF = 4;
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
      return b;
   endfunction
endpackage

// File: rtl/sync_w2r.sv
// sync_w2r: two-flop synchronizer bringing the write Gray pointer into the read clock domain.
module sync_w2r
   import fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] rq1_q, rq2_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= d;
         rq2_q <= rq1_q;
      end
   end
   assign q = rq2_q;
endmodule

// File: rtl/rptr_empty.sv
// rptr_empty: read pointer (binary/Gray), synchronized write pointer, and registered empty/almost-empty/occupancy.
module rptr_empty
   import fifo_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEF,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rinc,
   input  logic [WIDTH-1:0] wptr,
   output logic [WIDTH-2:0] raddr,
   output logic [WIDTH-1:0] rptr,
   output logic             rempty,
   output logic             raempty,
   output logic [WIDTH-1:0] rcount
);
   logic [WIDTH-1:0] rq2_wptr;
   logic [WIDTH-1:0] rbin_q, rbin_d, rptr_q, rptr_d, rcount_q, rcount_d;
   logic             rempty_q, rempty_d, raempty_q, raempty_d;
   sync_w2r #(.WIDTH(WIDTH)) u_sync (
      .clk(rclk),
      .rst(rrst),
      .d  (wptr),
      .q  (rq2_wptr)
   );
   // Flags use the next pointer, so the read that drains the last word raises empty on the same edge.
   always_comb begin
      rbin_d    = rbin_q + WIDTH'(rinc & ~rempty_q);
      rptr_d    = WIDTH'(bin2gray(32'(rbin_d)));
      rempty_d  = rptr_d == rq2_wptr;
      rcount_d  = WIDTH'(gray2bin(32'(rq2_wptr))) - rbin_d;
      raempty_d = 32'(rcount_d) <= 32'(AEMPTY_THRESH);
   end
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         rcount_q  <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rcount_q  <= rcount_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
      end
   end
   assign raddr   = rbin_q[WIDTH-2:0];
   assign rptr    = rptr_q;
   assign rcount  = rcount_q;
   assign rempty  = rempty_q;
   assign raempty = raempty_q;
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed vectors for rptr_empty; expected outputs are queued per cycle and checked by a monitor.
module tb_rptr_empty;
   logic       rclk = 1'b0;
   logic       rrst, rinc;
   logic [3:0] wptr;
   logic [2:0] raddr;
   logic [3:0] rptr, rcount;
   logic       rempty, raempty;
   typedef struct packed {
      logic [3:0] rptr;
      logic [2:0] raddr;
      logic       rempty;
      logic       raempty;
      logic [3:0] rcount;
   } exp_t;
   exp_t  eq[$];
   string tq[$];
   int    vectors = 0;
   int    miscompares = 0;
   rptr_empty #(.WIDTH(4), .AEMPTY_THRESH(1)) dut (
      .rclk   (rclk),
      .rrst   (rrst),
      .rinc   (rinc),
      .wptr   (wptr),
      .raddr  (raddr),
      .rptr   (rptr),
      .rempty (rempty),
      .raempty(raempty),
      .rcount (rcount)
   );
   always #5 rclk = ~rclk;
   function automatic logic [3:0] g(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction
   // Drive one cycle of inputs and queue the outputs expected after that edge.
   task automatic step(input logic rst, input logic inc, input logic [3:0] wp, input string tag,
                       input logic [3:0] ep, input int ea, input logic ee, input logic eae, input int ec);
      exp_t e;
      rrst = rst;
      rinc = inc;
      wptr = wp;
      @(posedge rclk);
      e.rptr    = ep;
      e.raddr   = ea[2:0];
      e.rempty  = ee;
      e.raempty = eae;
      e.rcount  = ec[3:0];
      eq.push_back(e);
      tq.push_back(tag);
      #1;
   endtask
   task automatic chk(input string tag, input string f, input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s %s: got %0d expected %0d", tag, f, act, exp);
      end
   endtask
   always @(negedge rclk) begin
      exp_t  e;
      string t;
      if (eq.size() > 0) begin
         e = eq.pop_front();
         t = tq.pop_front();
         chk(t, "rptr", rptr, e.rptr);
         chk(t, "raddr", {1'b0, raddr}, {1'b0, e.raddr});
         chk(t, "rempty", {3'b0, rempty}, {3'b0, e.rempty});
         chk(t, "raempty", {3'b0, raempty}, {3'b0, e.raempty});
         chk(t, "rcount", rcount, e.rcount);
      end
   end
   initial begin
      int base;
      logic [3:0] wp;
      step(1, 0, 4'b0110, "reset0", 0, 0, 1, 1, 0);
      step(1, 0, 4'b0110, "reset1", 0, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 4'b0000, "underflow", 0, 0, 1, 1, 0);
      step(0, 0, 4'b0001, "wlat0", 0, 0, 1, 1, 0);
      step(0, 0, 4'b0001, "wlat1", 0, 0, 1, 1, 0);
      step(0, 0, 4'b0001, "wlat2", 0, 0, 0, 1, 1);
      step(0, 1, 4'b0001, "rd_last", g(1), 1, 1, 1, 0);
      step(0, 0, 4'b0001, "rd_idle", g(1), 1, 1, 1, 0);
      step(1, 0, 4'b1100, "fill_rst", 0, 0, 1, 1, 0);
      step(0, 0, 4'b1100, "fill_s1", 0, 0, 1, 1, 0);
      step(0, 0, 4'b1100, "fill_s2", 0, 0, 1, 1, 0);
      step(0, 0, 4'b1100, "fill_full", 0, 0, 0, 0, 8);
      for (int k = 1; k <= 7; k++) step(0, 1, 4'b1100, "drain", g(k), k, 0, (8 - k) <= 1, 8 - k);
      step(0, 1, 4'b1100, "drain_last", g(8), 0, 1, 1, 0);
      // Blocks of five words move the read pointer 8..27, crossing 15->0 while data remains.
      base = 8;
      for (int b = 0; b < 4; b++) begin
         wp = g(base + 5);
         step(0, 0, wp, "wrap_s1", g(base), base, 1, 1, 0);
         step(0, 0, wp, "wrap_s2", g(base), base, 1, 1, 0);
         step(0, 0, wp, "wrap_s3", g(base), base, 0, 0, 5);
         for (int j = 1; j <= 5; j++)
            step(0, 1, wp, "wrap_rd", g(base + j), base + j, j == 5, (5 - j) <= 1, 5 - j);
         base += 5;
      end
      step(1, 0, g(5), "mr_pre_rst", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_sync1", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_sync2", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_cnt5", 0, 0, 0, 0, 5);
      step(1, 1, g(5), "mr_rst", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_s1", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_s2", 0, 0, 1, 1, 0);
      step(0, 0, g(5), "mr_back", 0, 0, 0, 0, 5);
      repeat (2) @(posedge rclk);
      if (eq.size() != 0) begin
         miscompares++;
         $display("FAIL monitor: %0d vectors still pending, expected 0", eq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
